// File: rtl/histeq_frame_ctrl.sv
// Runs one BMP frame from a byte memory through the histogram_equalization engine: header parse, full-file stream, output drain.
// Optional build macro HISTEQ_LEN_CHECK_EN: flag a drained byte count that differs from file_size as error code 4.
module histeq_frame_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int MAX_BYTES   = 650001,
  parameter int TIMEOUT_CYC = 4194304
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [31:0]       file_size,
  output logic [31:0]       data_offset,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              he_valid_in,
  output logic              he_image_write_done,
  output logic              he_bmp_write_done,
  output logic [7:0]        he_point_data_in,
  input  logic              he_init_done,
  input  logic              he_data_read_start,
  input  logic              he_data_read_done,
  input  logic [7:0]        he_point_data_out,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [31:0]       out_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_INIT, S_HDR, S_CHK, S_STREAM, S_WAIT_RD, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [31:0] wd;
  logic [31:0] rd_idx;
  logic [31:0] rd_nxt;
  logic [31:0] cap_idx;
  logic        rd_pend;
  logic        last_pres;
  logic        wd_exp;
  logic        hdr_ok;
  logic        drain_end;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  lane;

  assign rd_nxt    = rd_idx + 32'd1;
  assign wd_exp    = (wd == 32'(TIMEOUT_CYC - 1));
  assign hdr_ok    = (data_offset >= 32'd14) && (data_offset < file_size) &&
                     (file_size <= 32'(MAX_BYTES));
  // out_valid is the delayed read_start, so it doubles as rs_d1
  assign drain_end = !out_valid && he_data_read_done;
  // header bytes 2..5 and 10..13 both map to lanes 0..3 of their word
  assign lane      = cap_idx[1:0] - 2'd2;

  always_comb begin
    fault      = 1'b0;
    fault_code = 3'd0;
    case (state)
      S_WAIT_INIT: if (!he_init_done && wd_exp) begin
        fault      = 1'b1;
        fault_code = 3'd3;
      end
      S_HDR: if (rd_pend && ((cap_idx == 32'd0 && mem_rd_data != 8'h42) ||
                             (cap_idx == 32'd1 && mem_rd_data != 8'h4D))) begin
        fault      = 1'b1;
        fault_code = 3'd1;
      end
      S_CHK: if (!hdr_ok) begin
        fault      = 1'b1;
        fault_code = 3'd2;
      end
      S_WAIT_RD: if (!he_data_read_start && wd_exp) begin
        fault      = 1'b1;
        fault_code = 3'd3;
      end
      S_DRAIN: if (drain_end) begin
`ifdef HISTEQ_LEN_CHECK_EN
        if (out_count != file_size) begin
          fault      = 1'b1;
          fault_code = 3'd4;
        end
`endif
      end else if (wd_exp) begin
        fault      = 1'b1;
        fault_code = 3'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      wd                  <= '0;
      rd_idx              <= '0;
      cap_idx             <= '0;
      rd_pend             <= 1'b0;
      last_pres           <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
      err_code            <= '0;
      file_size           <= '0;
      data_offset         <= '0;
      mem_rd_en           <= 1'b0;
      mem_addr            <= '0;
      he_valid_in         <= 1'b0;
      he_image_write_done <= 1'b0;
      he_bmp_write_done   <= 1'b0;
      he_point_data_in    <= '0;
      out_valid           <= 1'b0;
      out_data            <= '0;
      out_count           <= '0;
    end else begin
      wd        <= wd + 32'd1;
      rd_pend   <= mem_rd_en;
      cap_idx   <= rd_idx;
      done      <= 1'b0;
      out_valid <= 1'b0;

      case (state)
        S_IDLE: ;
        S_WAIT_INIT: if (he_init_done) begin
          state     <= S_HDR;
          wd        <= '0;
          mem_rd_en <= 1'b1;
          mem_addr  <= '0;
          rd_idx    <= '0;
        end
        S_HDR: begin
          if (mem_rd_en) begin
            if (rd_idx == 32'd13) mem_rd_en <= 1'b0;
            else begin
              rd_idx   <= rd_nxt;
              mem_addr <= ADDR_W'(rd_nxt);
            end
          end
          if (rd_pend) begin
            if (cap_idx >= 32'd2 && cap_idx <= 32'd5)
              file_size[{lane, 3'b000} +: 8] <= mem_rd_data;
            if (cap_idx >= 32'd10 && cap_idx <= 32'd13)
              data_offset[{lane, 3'b000} +: 8] <= mem_rd_data;
            if (cap_idx == 32'd13) begin
              state <= S_CHK;
              wd    <= '0;
            end
          end
        end
        S_CHK: if (hdr_ok) begin
          state     <= S_STREAM;
          wd        <= '0;
          mem_rd_en <= 1'b1;
          mem_addr  <= '0;
          rd_idx    <= '0;
        end
        S_STREAM: begin
          if (mem_rd_en) begin
            if (rd_idx == file_size - 32'd1) mem_rd_en <= 1'b0;
            else begin
              rd_idx   <= rd_nxt;
              mem_addr <= ADDR_W'(rd_nxt);
            end
          end
          if (rd_pend) begin
            he_point_data_in <= mem_rd_data;
            if (cap_idx == data_offset)         he_image_write_done <= 1'b1;
            if (cap_idx == file_size - 32'd1)   last_pres <= 1'b1;
          end
          if (last_pres) begin
            he_bmp_write_done <= 1'b1;
            state             <= S_WAIT_RD;
            wd                <= '0;
          end
        end
        S_WAIT_RD: if (he_data_read_start) begin
          out_valid <= 1'b1;
          out_data  <= he_point_data_out;
          out_count <= out_count + 32'd1;
          state     <= S_DRAIN;
          wd        <= '0;
        end
        S_DRAIN: begin
          if (he_data_read_start) begin
            out_valid <= 1'b1;
            out_data  <= he_point_data_out;
            out_count <= out_count + 32'd1;
          end
          if (drain_end) begin
            state       <= S_DONE;
            wd          <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            he_valid_in <= 1'b0;
          end
        end
        S_DONE: begin
          state               <= S_IDLE;
          wd                  <= '0;
          he_image_write_done <= 1'b0;
          he_bmp_write_done   <= 1'b0;
        end
        S_ERR: begin
          state <= S_IDLE;
          wd    <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (fault) begin
        state               <= S_ERR;
        wd                  <= '0;
        err                 <= 1'b1;
        err_code            <= fault_code;
        busy                <= 1'b0;
        done                <= 1'b0;
        he_valid_in         <= 1'b0;
        he_image_write_done <= 1'b0;
        he_bmp_write_done   <= 1'b0;
        mem_rd_en           <= 1'b0;
        out_valid           <= 1'b0;
      end

      // DONE and ERR already report busy=0, so a start there is taken too
      if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
        state               <= S_WAIT_INIT;
        wd                  <= '0;
        busy                <= 1'b1;
        he_valid_in         <= 1'b1;
        err                 <= 1'b0;
        err_code            <= '0;
        out_count           <= '0;
        last_pres           <= 1'b0;
        he_image_write_done <= 1'b0;
        he_bmp_write_done   <= 1'b0;
      end
    end
  end

endmodule
